// File: rtl/msg_digit_serializer_if.sv
// rtl/msg_digit_serializer_if.sv - load/stream bundle for the message digit serializer
//
// Purpose: groups the message load handshake, flush control and the digit
// output stream so producer/consumer and serializer connect with one port.
// Ports (signals):
//   load_valid/load_ready  message load handshake
//   initial_msg            message to serialise (MSG_SIZE bits)
//   lsb_first              digit order, sampled with the message
//   flush                  synchronous abort of the current message
//   out_digit/out_valid/out_ready/out_last  digit stream
//   remaining              digits still to transfer, including the current one
// Modports: master = message source / digit consumer, slave = serializer.

interface msg_digit_serializer_if #(
    parameter int MSG_SIZE = 32,
    parameter int DIGIT_W  = 4
);
    localparam int N_DIGITS = MSG_SIZE / DIGIT_W;
    localparam int CNT_W    = $clog2(N_DIGITS + 1);

    logic                load_valid;
    logic                load_ready;
    logic [MSG_SIZE-1:0] initial_msg;
    logic                lsb_first;
    logic                flush;
    logic [DIGIT_W-1:0]  out_digit;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [CNT_W-1:0]    remaining;

    modport master (
        output load_valid, initial_msg, lsb_first, flush, out_ready,
        input  load_ready, out_digit, out_valid, out_last, remaining
    );

    modport slave (
        input  load_valid, initial_msg, lsb_first, flush, out_ready,
        output load_ready, out_digit, out_valid, out_last, remaining
    );
endinterface

// File: rtl/msg_digit_serializer.sv
// rtl/msg_digit_serializer.sv - serialises a MSG_SIZE-bit message into DIGIT_W-bit digits
//
// Purpose: accepts a message over a valid/ready load handshake and emits it
// as MSG_SIZE/DIGIT_W digits, MSB- or LSB-first per message, over a
// valid/ready stream with backpressure. Back-to-back messages run without
// an idle cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  msg_digit_serializer_if.slave (load handshake, flush, digit stream)

module msg_digit_serializer #(
    parameter int MSG_SIZE = 32,
    parameter int DIGIT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    msg_digit_serializer_if.slave bus
);
    localparam int N_DIGITS = MSG_SIZE / DIGIT_W;
    localparam int CNT_W    = $clog2(N_DIGITS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic [MSG_SIZE-1:0] shreg, shreg_nx;
    logic [CNT_W-1:0]    rem_q, rem_nx;
    logic                lsb_mode, lsb_mode_nx;

    logic                valid_w;
    logic                last_w;
    logic                load_ready_w;
    logic                xfer;
    logic                load_acc;

    // All outputs come from registers plus out_ready/flush only, so the
    // load side never has a combinational path to the stream side.
    assign valid_w      = (state == SHIFT);
    assign last_w       = valid_w && (rem_q == CNT_W'(1));
    // Accept a new message while the final digit is leaving: zero-bubble
    // back-to-back messages.
    assign load_ready_w = !bus.flush && ((state == IDLE) || (last_w && bus.out_ready));
    assign xfer         = valid_w && bus.out_ready;
    assign load_acc     = bus.load_valid && load_ready_w;

    assign bus.out_valid  = valid_w;
    assign bus.out_last   = last_w;
    assign bus.load_ready = load_ready_w;
    assign bus.remaining  = rem_q;
    assign bus.out_digit  = !valid_w ? '0 :
                            lsb_mode ? shreg[DIGIT_W-1:0] :
                                       shreg[MSG_SIZE-1 -: DIGIT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            rem_q    <= '0;
            lsb_mode <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            rem_q    <= rem_nx;
            lsb_mode <= lsb_mode_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        rem_nx      = rem_q;
        lsb_mode_nx = lsb_mode;

        if (bus.flush) begin
            // A transfer on this cycle still completes at the consumer; the
            // rest of the message is simply discarded here.
            state_nx = IDLE;
            shreg_nx = '0;
            rem_nx   = '0;
        end else if (load_acc) begin
            // Covers both IDLE loads and a load overlapping the last transfer.
            state_nx    = SHIFT;
            shreg_nx    = bus.initial_msg;
            rem_nx      = CNT_W'(N_DIGITS);
            lsb_mode_nx = bus.lsb_first;
        end else if (xfer) begin
            shreg_nx = lsb_mode ? (shreg >> DIGIT_W) : (shreg << DIGIT_W);
            rem_nx   = rem_q - CNT_W'(1);
            if (last_w) begin
                state_nx = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_msg_digit_serializer.sv
// tb/tb_msg_digit_serializer.sv - directed self-checking bench for msg_digit_serializer

module tb_msg_digit_serializer;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   vectors;
    int   miscompares;

    logic [15:0] msg16;
    logic [31:0] msg32;

    localparam logic [3:0] BP_D   [7] = '{4'hA, 4'h5, 4'h5, 4'h5, 4'hC, 4'hC, 4'h3};
    localparam logic [2:0] BP_REM [7] = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1};
    localparam logic       BP_RDY [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    msg_digit_serializer_if #(.MSG_SIZE(16), .DIGIT_W(4)) a_if ();
    msg_digit_serializer_if #(.MSG_SIZE(32), .DIGIT_W(8)) b_if ();

    msg_digit_serializer #(.MSG_SIZE(16), .DIGIT_W(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if)
    );

    msg_digit_serializer #(.MSG_SIZE(32), .DIGIT_W(8)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] d, input logic [2:0] r, input logic l);
        chk({tag, "_valid"}, 32'(a_if.out_valid), 32'd1);
        chk({tag, "_digit"}, 32'(a_if.out_digit), 32'(d));
        chk({tag, "_rem"},   32'(a_if.remaining), 32'(r));
        chk({tag, "_last"},  32'(a_if.out_last),  32'(l));
    endtask

    task automatic chk_b(input string tag, input logic [7:0] d, input logic [2:0] r, input logic l);
        chk({tag, "_valid"}, 32'(b_if.out_valid), 32'd1);
        chk({tag, "_digit"}, 32'(b_if.out_digit), 32'(d));
        chk({tag, "_rem"},   32'(b_if.remaining), 32'(r));
        chk({tag, "_last"},  32'(b_if.out_last),  32'(l));
    endtask

    task automatic idle_a(input string tag);
        chk({tag, "_valid"}, 32'(a_if.out_valid),  32'd0);
        chk({tag, "_digit"}, 32'(a_if.out_digit),  32'd0);
        chk({tag, "_rem"},   32'(a_if.remaining),  32'd0);
        chk({tag, "_last"},  32'(a_if.out_last),   32'd0);
        chk({tag, "_lrdy"},  32'(a_if.load_ready), 32'd1);
    endtask

    task automatic idle_b(input string tag);
        chk({tag, "_valid"}, 32'(b_if.out_valid),  32'd0);
        chk({tag, "_digit"}, 32'(b_if.out_digit),  32'd0);
        chk({tag, "_rem"},   32'(b_if.remaining),  32'd0);
        chk({tag, "_last"},  32'(b_if.out_last),   32'd0);
        chk({tag, "_lrdy"},  32'(b_if.load_ready), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.load_valid = 1'b0; a_if.initial_msg = '0; a_if.lsb_first = 1'b0;
        a_if.flush = 1'b0;      a_if.out_ready = 1'b0;
        b_if.load_valid = 1'b0; b_if.initial_msg = '0; b_if.lsb_first = 1'b0;
        b_if.flush = 1'b0;      b_if.out_ready = 1'b0;

        // Reset state
        #1;
        idle_a("rst_a");
        idle_b("rst_b");
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // 1: MSB-first A5C3 -> A,5,C,3
        msg16 = 16'hA5C3;
        @(negedge clk);
        a_if.initial_msg = msg16; a_if.lsb_first = 1'b0;
        a_if.load_valid = 1'b1;   a_if.out_ready = 1'b1;
        #1 chk("t1_lrdy", 32'(a_if.load_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_if.load_valid = 1'b0;
            #1 chk_a($sformatf("t1_d%0d", i), 4'(msg16 >> (12 - 4 * i)), 3'(4 - i), i == 3);
        end
        @(negedge clk);
        #1 idle_a("t1_end");

        // 2: LSB-first A5C3 -> 3,C,5,A; mode flip mid-message has no effect
        @(negedge clk);
        a_if.initial_msg = msg16; a_if.lsb_first = 1'b1; a_if.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_if.load_valid = 1'b0;
            if (i == 1) a_if.lsb_first = 1'b0;
            #1 chk_a($sformatf("t2_d%0d", i), 4'(msg16 >> (4 * i)), 3'(4 - i), i == 3);
        end
        @(negedge clk);
        #1 idle_a("t2_end");

        // 3: backpressure with out_ready 1,0,0,1,0,1,1
        @(negedge clk);
        a_if.initial_msg = msg16; a_if.lsb_first = 1'b0; a_if.load_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_if.load_valid = 1'b0;
            a_if.out_ready  = BP_RDY[i];
            #1 chk_a($sformatf("t3_c%0d", i), BP_D[i], BP_REM[i], BP_REM[i] == 3'd1);
        end
        @(negedge clk);
        a_if.out_ready = 1'b1;
        #1 idle_a("t3_end");

        // 4: back-to-back 1234 then BEEF -> 1,2,3,4,B,E,E,F
        msg32 = 32'h1234BEEF;
        @(negedge clk);
        a_if.initial_msg = 16'h1234; a_if.load_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) a_if.initial_msg = 16'hBEEF;
            if (i == 4) a_if.load_valid = 1'b0;
            #1;
            chk_a($sformatf("t4_d%0d", i), 4'(msg32 >> (28 - 4 * i)), 3'(4 - (i % 4)), (i % 4) == 3);
            chk($sformatf("t4_lrdy%0d", i), 32'(a_if.load_ready), 32'((i % 4) == 3));
        end
        @(negedge clk);
        #1 idle_a("t4_end");

        // 5: flush after 2 digits, then 0F0F -> 0,F,0,F
        @(negedge clk);
        a_if.initial_msg = msg16; a_if.load_valid = 1'b1;
        @(negedge clk);
        a_if.load_valid = 1'b0;
        #1 chk_a("t5_d0", 4'hA, 3'd4, 1'b0);
        @(negedge clk);
        #1 chk_a("t5_d1", 4'h5, 3'd3, 1'b0);
        @(negedge clk);
        a_if.flush = 1'b1; a_if.out_ready = 1'b0;
        #1;
        chk("t5_flush_lrdy", 32'(a_if.load_ready), 32'd0);
        chk_a("t5_flush", 4'hC, 3'd2, 1'b0);
        @(negedge clk);
        a_if.flush = 1'b0; a_if.out_ready = 1'b1;
        #1 idle_a("t5_after");
        msg16 = 16'h0F0F;
        a_if.initial_msg = msg16; a_if.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_if.load_valid = 1'b0;
            #1 chk_a($sformatf("t5_n%0d", i), 4'(msg16 >> (12 - 4 * i)), 3'(4 - i), i == 3);
        end
        @(negedge clk);
        #1 idle_a("t5_end");

        // 6: async reset between edges while remaining=3
        @(negedge clk);
        a_if.initial_msg = 16'hA5C3; a_if.load_valid = 1'b1;
        @(negedge clk);
        a_if.load_valid = 1'b0;
        #1 chk_a("t6_d0", 4'hA, 3'd4, 1'b0);
        @(negedge clk);
        a_if.out_ready = 1'b0;
        #1 chk_a("t6_d1", 4'h5, 3'd3, 1'b0);
        #1 rst_a = 1'b1;
        #1 idle_a("t6_rst");
        // first accept on the first edge after reset falls; LSB-first 7E81 -> 1,8,E,7
        @(negedge clk);
        rst_a = 1'b0;
        msg16 = 16'h7E81;
        a_if.initial_msg = msg16; a_if.lsb_first = 1'b1;
        a_if.load_valid = 1'b1;   a_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_if.load_valid = 1'b0;
            #1 chk_a($sformatf("t6_n%0d", i), 4'(msg16 >> (4 * i)), 3'(4 - i), i == 3);
        end

        // 7: MSG_SIZE=32, DIGIT_W=8: async reset mid-message, then DE,AD,BE,EF
        msg32 = 32'hDEADBEEF;
        @(negedge clk);
        b_if.initial_msg = msg32; b_if.load_valid = 1'b1; b_if.out_ready = 1'b1;
        @(negedge clk);
        b_if.load_valid = 1'b0;
        #1 chk_b("t7_d0", 8'hDE, 3'd4, 1'b0);
        @(negedge clk);
        #1 chk_b("t7_d1", 8'hAD, 3'd3, 1'b0);
        #1 rst_b = 1'b1;
        #1 idle_b("t7_rst");
        @(negedge clk);
        rst_b = 1'b0;
        b_if.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_if.load_valid = 1'b0;
            #1 chk_b($sformatf("t7_n%0d", i), 8'(msg32 >> (24 - 8 * i)), 3'(4 - i), i == 3);
        end
        @(negedge clk);
        #1 idle_b("t7_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
